// File: rtl/decode_stage.sv
// decode_stage
//   Decode stage that sits directly in front of the execute ALU. Takes RV32
//   instruction words from fetch over a valid/ready handshake, decodes the
//   small supported subset (LUI, ADDI, ADD/SUB/MUL/DIV) into ALU control
//   fields, and reads both operands from an internal 32x32 register file
//   written by the writeback port. Results sit in one registered output slot
//   with valid/ready backpressure (1-cycle latency, full throughput).
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_instr    instruction input handshake
//   out_valid/out_ready           output slot handshake
//   is_lui, is_i_type, alu_ops,   decoded control fields
//   imm, rd_addr, rd_we, illegal
//   rs1_data, rs2_data            captured operands
//   wb_en, wb_addr, wb_data       register file write port
module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_lui,
  output logic            is_i_type,
  output logic [3:0]      alu_ops,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign opcode  = in_instr[6:0];
  assign rd_idx  = in_instr[11:7];
  assign funct3  = in_instr[14:12];
  assign rs1_idx = in_instr[19:15];
  assign rs2_idx = in_instr[24:20];
  assign funct7  = in_instr[31:25];

  // Decoded fields for the incoming instruction
  logic            dec_is_lui;
  logic            dec_is_i_type;
  logic [3:0]      dec_alu_ops;
  logic [XLEN-1:0] dec_imm;
  logic            dec_writes;
  logic            dec_illegal;
  logic            dec_rd_we;

  always_comb begin
    dec_is_lui    = 1'b0;
    dec_is_i_type = 1'b0;
    dec_alu_ops   = 4'b0000;
    dec_imm       = '0;
    dec_writes    = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_LUI: begin
        // Left unshifted: execute applies the 12-bit shift itself.
        dec_is_lui = 1'b1;
        dec_imm    = {12'b0, in_instr[31:12]};
        dec_writes = 1'b1;
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          dec_is_i_type = 1'b1;
          dec_imm       = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_writes    = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_REG: begin
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: begin dec_alu_ops = 4'b0000; dec_writes = 1'b1; end
          {7'b0100000, 3'b000}: begin dec_alu_ops = 4'b0001; dec_writes = 1'b1; end
          {7'b0000001, 3'b000}: begin dec_alu_ops = 4'b1100; dec_writes = 1'b1; end
          {7'b0000001, 3'b100}: begin dec_alu_ops = 4'b1101; dec_writes = 1'b1; end
          default:              dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // x0 is never a real destination.
  assign dec_rd_we = dec_writes && (rd_idx != 5'd0);

  // Register file. Entry 0 is never written and reads are forced to zero.
  logic [XLEN-1:0] regs [32];
  logic            wb_live;

  assign wb_live = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Operand read with optional same-cycle writeback forwarding.
  logic [XLEN-1:0] rs1_read;
  logic [XLEN-1:0] rs2_read;

  always_comb begin
    rs1_read = '0;
    rs2_read = '0;
    if (rs1_idx != 5'd0) begin
      if (WB_BYPASS && wb_en && (wb_addr == rs1_idx)) rs1_read = wb_data;
      else                                            rs1_read = regs[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      if (WB_BYPASS && wb_en && (wb_addr == rs2_idx)) rs2_read = wb_data;
      else                                            rs2_read = regs[rs2_idx];
    end
  end

  // Handshake
  logic out_valid_reg;
  logic accept;

  assign in_ready = !rst && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Output slot
  logic            is_lui_reg;
  logic            is_i_type_reg;
  logic [3:0]      alu_ops_reg;
  logic [XLEN-1:0] imm_reg;
  logic [4:0]      rd_addr_reg;
  logic            rd_we_reg;
  logic            illegal_reg;
  logic [XLEN-1:0] rs1_data_reg;
  logic [XLEN-1:0] rs2_data_reg;
  // Source indices of the held instruction, kept so a stalled slot can
  // pick up writebacks that land after capture.
  logic [4:0]      rs1_idx_reg;
  logic [4:0]      rs2_idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      is_lui_reg    <= 1'b0;
      is_i_type_reg <= 1'b0;
      alu_ops_reg   <= 4'b0000;
      imm_reg       <= '0;
      rd_addr_reg   <= 5'd0;
      rd_we_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      rs1_data_reg  <= '0;
      rs2_data_reg  <= '0;
      rs1_idx_reg   <= 5'd0;
      rs2_idx_reg   <= 5'd0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      is_lui_reg    <= dec_is_lui;
      is_i_type_reg <= dec_is_i_type;
      alu_ops_reg   <= dec_alu_ops;
      imm_reg       <= dec_imm;
      rd_addr_reg   <= rd_idx;
      rd_we_reg     <= dec_rd_we;
      illegal_reg   <= dec_illegal;
      rs1_data_reg  <= rs1_read;
      rs2_data_reg  <= rs2_read;
      rs1_idx_reg   <= rs1_idx;
      rs2_idx_reg   <= rs2_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end else if (out_valid_reg && WB_BYPASS) begin
      // Stalled: keep held operands coherent with the register file.
      if (wb_live && (wb_addr == rs1_idx_reg)) rs1_data_reg <= wb_data;
      if (wb_live && (wb_addr == rs2_idx_reg)) rs2_data_reg <= wb_data;
    end
  end

  assign out_valid = out_valid_reg;
  assign is_lui    = is_lui_reg;
  assign is_i_type = is_i_type_reg;
  assign alu_ops   = alu_ops_reg;
  assign imm       = imm_reg;
  assign rd_addr   = rd_addr_reg;
  assign rd_we     = rd_we_reg;
  assign illegal   = illegal_reg;
  assign rs1_data  = rs1_data_reg;
  assign rs2_data  = rs2_data_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table-driven decode vectors, hand-written
// stall/bypass/reset sequences, and randomized traffic checked every cycle
// against a behavioural model (architectural register array + one slot).
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic        is_lui;
  logic        is_i_type;
  logic [3:0]  alu_ops;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  decode_stage #(.XLEN(32), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_lui(is_lui), .is_i_type(is_i_type), .alu_ops(alu_ops),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        is_lui;
    logic        is_i;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } dec_t;

  // Classify the word by masking out the fields that don't matter.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.rd = w[11:7];
    if ((w & 32'h0000007F) == 32'h00000037) begin
      d.is_lui = 1'b1; d.imm = w >> 12; d.we = 1'b1;
    end else if ((w & 32'h0000707F) == 32'h00000013) begin
      d.is_i = 1'b1; d.imm = $signed(w) >>> 20; d.we = 1'b1;
    end else if ((w & 32'hFE00707F) == 32'h00000033) begin
      d.alu = 4'h0; d.we = 1'b1;
    end else if ((w & 32'hFE00707F) == 32'h40000033) begin
      d.alu = 4'h1; d.we = 1'b1;
    end else if ((w & 32'hFE00707F) == 32'h02000033) begin
      d.alu = 4'hC; d.we = 1'b1;
    end else if ((w & 32'hFE00707F) == 32'h02004033) begin
      d.alu = 4'hD; d.we = 1'b1;
    end else begin
      d.illegal = 1'b1;
    end
    if (d.rd == 5'd0) d.we = 1'b0;
    return d;
  endfunction

  logic [31:0] m_regs [32];
  logic        m_valid;
  dec_t        m_dec;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic [4:0]  m_i1;
  logic [4:0]  m_i2;

  // Architectural value of a register as seen by an instruction captured
  // this cycle (includes the writeback landing this cycle).
  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic ref_in_ready();
    return !rst && (!m_valid || out_ready);
  endfunction

  task automatic model_update();
    logic acc;
    acc = in_valid && ref_in_ready();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_valid = 1'b0; m_dec = '0; m_rs1 = 32'h0; m_rs2 = 32'h0;
      m_i1 = 5'd0; m_i2 = 5'd0;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_dec   = ref_decode(in_instr);
        m_i1    = in_instr[19:15];
        m_i2    = in_instr[24:20];
        m_rs1   = ref_read(m_i1);
        m_rs2   = ref_read(m_i2);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        if (wb_en && wb_addr != 5'd0 && wb_addr == m_i1) m_rs1 = wb_data;
        if (wb_en && wb_addr != 5'd0 && wb_addr == m_i2) m_rs2 = wb_data;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    end
  endtask

  task automatic compare_model();
    chk("m.out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("m.is_lui",    {31'b0, is_lui},    {31'b0, m_dec.is_lui});
      chk("m.is_i_type", {31'b0, is_i_type}, {31'b0, m_dec.is_i});
      chk("m.alu_ops",   {28'b0, alu_ops},   {28'b0, m_dec.alu});
      chk("m.imm",       imm,                m_dec.imm);
      chk("m.rd_addr",   {27'b0, rd_addr},   {27'b0, m_dec.rd});
      chk("m.rd_we",     {31'b0, rd_we},     {31'b0, m_dec.we});
      chk("m.illegal",   {31'b0, illegal},   {31'b0, m_dec.illegal});
      chk("m.rs1_data",  rs1_data,           m_rs1);
      chk("m.rs2_data",  rs2_data,           m_rs2);
    end
  endtask

  // One clock: check in_ready with settled inputs, clock, update the model,
  // compare outputs 1 time unit after the edge.
  task automatic step();
    #1;
    chk("m.in_ready", {31'b0, in_ready}, {31'b0, ref_in_ready()});
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  // ---------------- decode vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic        is_lui;
    logic        is_i;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // instr, is_lui, is_i, alu, imm, rd, rd_we, illegal, rs1, rs2  (x1=7, x2=3)
    vecs[0]  = '{32'h00500093, 1'b0, 1'b1, 4'h0, 32'h00000005, 5'd1, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[1]  = '{32'hFFF00093, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[2]  = '{32'h12345137, 1'b1, 1'b0, 4'h0, 32'h00012345, 5'd2, 1'b1, 1'b0, 32'd0, 32'd0};
    vecs[3]  = '{32'h002081B3, 1'b0, 1'b0, 4'h0, 32'h00000000, 5'd3, 1'b1, 1'b0, 32'd7, 32'd3};
    vecs[4]  = '{32'h402081B3, 1'b0, 1'b0, 4'h1, 32'h00000000, 5'd3, 1'b1, 1'b0, 32'd7, 32'd3};
    vecs[5]  = '{32'h022081B3, 1'b0, 1'b0, 4'hC, 32'h00000000, 5'd3, 1'b1, 1'b0, 32'd7, 32'd3};
    vecs[6]  = '{32'h0220C1B3, 1'b0, 1'b0, 4'hD, 32'h00000000, 5'd3, 1'b1, 1'b0, 32'd7, 32'd3};
    vecs[7]  = '{32'h00000000, 1'b0, 1'b0, 4'h0, 32'h00000000, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0};
    vecs[8]  = '{32'h00100013, 1'b0, 1'b1, 4'h0, 32'h00000001, 5'd0, 1'b0, 1'b0, 32'd0, 32'd7};
    vecs[9]  = '{32'h00502093, 1'b0, 1'b0, 4'h0, 32'h00000000, 5'd1, 1'b0, 1'b1, 32'd0, 32'd0};
    vecs[10] = '{32'h002091B3, 1'b0, 1'b0, 4'h0, 32'h00000000, 5'd3, 1'b0, 1'b1, 32'd7, 32'd3};
    vecs[11] = '{32'h00000013, 1'b0, 1'b1, 4'h0, 32'h00000000, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0};
  end

  // ---------------- random instruction generator ----------------
  function automatic logic [31:0] rand_instr();
    logic [31:0] rd, r1, r2, w;
    int kind;
    rd   = 32'($urandom_range(0, 7));
    r1   = 32'($urandom_range(0, 7));
    r2   = 32'($urandom_range(0, 7));
    kind = int'($urandom_range(0, 6));
    case (kind)
      0: w = ($urandom() & 32'hFFFFF000) | (rd << 7) | 32'h37;
      1: w = ($urandom() & 32'hFFF00000) | (r1 << 15) | (rd << 7) | 32'h13;
      2: w = (r2 << 20) | (r1 << 15) | (rd << 7) | 32'h33;
      3: w = 32'h40000000 | (r2 << 20) | (r1 << 15) | (rd << 7) | 32'h33;
      4: w = 32'h02000000 | (r2 << 20) | (r1 << 15) | (rd << 7) | 32'h33;
      5: w = 32'h02004000 | (r2 << 20) | (r1 << 15) | (rd << 7) | 32'h33;
      default: w = $urandom();
    endcase
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    m_valid = 1'b0; m_dec = '0; m_rs1 = 32'h0; m_rs2 = 32'h0; m_i1 = 5'd0; m_i2 = 5'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    step();
    step();
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.imm", imm, 32'd0);
    chk("rst.rd_we", {31'b0, rd_we}, 32'd0);
    chk("rst.alu_ops", {28'b0, alu_ops}, 32'd0);
    rst = 1'b0;
    step();

    // Preload operands
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd3);

    // Table-driven decode, issued back to back
    out_ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      in_valid = 1'b1;
      in_instr = vecs[v].instr;
      step();
      $display("vec %0d instr=%h alu=%h imm=%h rd=%0d we=%0d ill=%0d",
               v, in_instr, alu_ops, imm, rd_addr, rd_we, illegal);
      chk("vec.in_ready",  {31'b0, in_ready},  32'd1);
      chk("vec.out_valid", {31'b0, out_valid}, 32'd1);
      chk("vec.is_lui",    {31'b0, is_lui},    {31'b0, vecs[v].is_lui});
      chk("vec.is_i_type", {31'b0, is_i_type}, {31'b0, vecs[v].is_i});
      chk("vec.alu_ops",   {28'b0, alu_ops},   {28'b0, vecs[v].alu});
      chk("vec.imm",       imm,                vecs[v].imm);
      chk("vec.rd_addr",   {27'b0, rd_addr},   {27'b0, vecs[v].rd});
      chk("vec.rd_we",     {31'b0, rd_we},     {31'b0, vecs[v].rd_we});
      chk("vec.illegal",   {31'b0, illegal},   {31'b0, vecs[v].illegal});
      chk("vec.rs1_data",  rs1_data,           vecs[v].rs1);
      chk("vec.rs2_data",  rs2_data,           vecs[v].rs2);
    end
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

    // Stall with held ADD, refresh via writeback, then drain+refill
    in_valid = 1'b1; in_instr = 32'h002081B3; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_instr = 32'h402081B3;
    #1;
    chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("stall.alu_ops", {28'b0, alu_ops}, 32'h0);
    chk("stall.rs2_data", rs2_data, 32'd3);
    wb(5'd2, 32'd9);
    chk("refresh.rs2_data", rs2_data, 32'd9);
    chk("refresh.alu_ops", {28'b0, alu_ops}, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("refill.in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("refill.alu_ops", {28'b0, alu_ops}, 32'h1);
    chk("refill.rs2_data", rs2_data, 32'd9);

    // Accept in the same cycle as a writeback to rs1
    in_instr = 32'h002081B3;
    wb(5'd1, 32'h55);
    chk("bypass.rs1_data", rs1_data, 32'h55);
    step();
    chk("after_wb.rs1_data", rs1_data, 32'h55);

    // Reset while holding a valid slot and writing x5
    out_ready = 1'b0;
    rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    step();
    chk("rst2.out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0; wb_en = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h001281B3;  // ADD x3,x5,x1
    step();
    chk("rst2.rs1_data", rs1_data, 32'd0);
    chk("rst2.rs2_data", rs2_data, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 9) < 7);
      wb_en     = $urandom_range(0, 1) == 1;
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage directly upstream of the execute ALU.
- Accepts 32-bit RV32 instructions from fetch over a valid/ready handshake and decodes them into the ALU control fields (is_lui, is_i_type, alu_ops, imm).
- Reads operands from an internal 32x32 register file, written by the writeback port.
- Presents the result through a single registered output slot with valid/ready backpressure.

Parameters:
- XLEN, 32, data width; only 32 supported.
- WB_BYPASS, 1, when 1, a same-cycle writeback is forwarded into operand capture and into the held output slot.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  instruction word.
- out_valid  output  1  output slot holds a decoded instruction.
- out_ready  input  1  execute consumes the slot this cycle.
- is_lui  output  1  LUI.
- is_i_type  output  1  ADDI.
- alu_ops  output  4  R-type op select.
- rs1_data  output  32  operand 1.
- rs2_data  output  32  operand 2.
- imm  output  32  immediate.
- rd_addr  output  5  destination register.
- rd_we  output  1  destination write enable.
- illegal  output  1  unsupported encoding.
- wb_en  input  1  register file write enable.
- wb_addr  input  5  write address.
- wb_data  input  32  write data.

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0; all decoded outputs 0.
  - All 32 registers cleared to 0.
  - rst has priority over accept and over wb write in the same cycle.
  - An instruction in flight is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; forced 0 while rst=1).
  - Accept = in_valid && in_ready. On accept, the slot loads the decoded fields and out_valid=1 next cycle.
  - Slot drains and refills in the same cycle at full throughput: one instruction per cycle, 1-cycle latency.
  - If out_ready && !accept, out_valid goes to 0.
  - If out_valid && !out_ready, all outputs hold stable, except for the operand refresh below.
- Decode, keyed on opcode = instr[6:0]:
  - 0110111 (LUI): is_lui=1; imm={12'b0, instr[31:12]}, unshifted because execute shifts by 12; rd_we=1.
  - 0010011 with funct3=000 (ADDI): is_i_type=1; imm=sign-extended instr[31:20]; rd_we=1.
  - 0110011 (R-type), by funct7/funct3; rd_we=1 for all four:
    - 0000000/000 gives alu_ops=0000 (ADD).
    - 0100000/000 gives alu_ops=0001 (SUB).
    - 0000001/000 gives alu_ops=1100 (MUL).
    - 0000001/100 gives alu_ops=1101 (DIV).
  - Anything else: illegal=1; is_lui=is_i_type=rd_we=0; alu_ops=0000; imm=0. Still passes through the handshake; never stalls.
  - rd_addr=instr[11:7] always.
  - Register sources: rs1=instr[19:15], rs2=instr[24:20].
  - rd_we forced 0 when rd_addr=0.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write occurs at the edge when wb_en=1 and rst=0.
- Bypass (WB_BYPASS=1):
  - On accept, if wb_en && wb_addr!=0 && wb_addr==rs1 (resp. rs2), the captured operand is wb_data, not the stale array value.
  - While stalled, if wb_en && wb_addr!=0 matches the held rs1 (resp. rs2) index, the held rs1_data/rs2_data updates to wb_data. Held indices are stored internally.
- Bypass disabled (WB_BYPASS=0): operands read the array pre-write; no refresh.
- Simultaneous accept plus wb to the same register: bypass value wins.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, is_i_type=1, imm=0x00000005, rs1_data=0, rd_addr=1, rd_we=1.
- ADDI x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF. LUI x2,0x12345 (0x12345137) -> is_lui=1, imm=0x00012345, rd_addr=2.
- Preload via wb (x1=7, x2=3); issue 0x002081B3, 0x402081B3, 0x022081B3, 0x0220C1B3 back-to-back -> alu_ops 0000, 0001, 1100, 1101 on consecutive cycles, rs1_data=7, rs2_data=3, in_ready stays 1.
- out_ready=0 with ADD held -> in_ready=0, outputs frozen. Then wb_en x2=9 -> rs2_data becomes 9 next cycle. Raise out_ready -> slot drains, a new instruction is accepted the same cycle.
- Accept ADD x3,x1,x2 in the same cycle as wb x1=0x55 -> rs1_data=0x55. Instruction 0x00000000 -> illegal=1, rd_we=0. ADDI x0,x0,1 -> rd_we=0.
- Assert rst while out_valid=1 and wb_en=1 (x5=0xAA) -> out_valid=0, x5 reads 0 afterwards.
